// File: rtl/front_panel.sv
// front_panel: debounced buttons/mode switch, CPU clock generator (auto/manual with halt) and registered LED drive
module front_panel #(
  parameter int N_BTN          = 4,
  parameter int DB_CYCLES      = 270000,
  parameter int AUTO_DIV       = 13500000,
  parameter bit BTN_ACTIVE_LOW = 1'b0,
  parameter int LED_W          = 6,
  parameter bit LED_ACTIVE_LOW = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic             mode_raw,
  input  logic             halt,
  input  logic [LED_W-1:0] led_in,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic             mode_level,
  output logic             cpu_clk,
  output logic             cpu_clk_rise,
  output logic [LED_W-1:0] led_out
);
  localparam int NI = N_BTN + 1;
  localparam int CW = $clog2(DB_CYCLES) + 1;
  localparam int DW = $clog2(AUTO_DIV) + 1;
  logic [NI-1:0] s1, s2, stable;
  logic [DW-1:0] div, div_nxt;
  logic mode_q, chg, tc, clk_nxt;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= {mode_raw, btn_raw} ^ {NI{BTN_ACTIVE_LOW}};
      s2 <= s1;
    end
  // mode switch shares the debouncer as the top bit
  for (genvar i = 0; i < NI; i++) begin : g_db
    logic [CW-1:0] cnt;
    logic st, acc;
    assign acc = s2[i] != st && cnt == CW'(DB_CYCLES - 1);
    assign stable[i] = st;
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        cnt <= '0;
        st  <= 1'b0;
      end else begin
        cnt <= (s2[i] == st || acc) ? '0 : cnt + 1'b1;
        st  <= acc ? s2[i] : st;
      end
    if (i < N_BTN) begin : g_pr
      logic pr;
      assign btn_press[i] = pr;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) pr <= 1'b0;
        else pr <= acc & s2[i];
    end
  end
  assign btn_level  = stable[N_BTN-1:0];
  assign mode_level = stable[N_BTN];
  // a mode change freezes cpu_clk for one cycle while the divider restarts
  always_comb begin
    chg     = mode_level != mode_q;
    tc      = div == DW'(AUTO_DIV - 1);
    div_nxt = (chg || !mode_level || tc) ? '0 : div + 1'b1;
    clk_nxt = chg ? cpu_clk :
              mode_level ? (tc ? (~cpu_clk & ~halt) : cpu_clk) :
              btn_level[0] & ~(halt & ~cpu_clk);
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      div          <= '0;
      mode_q       <= 1'b0;
      cpu_clk      <= 1'b0;
      cpu_clk_rise <= 1'b0;
      led_out      <= {LED_W{LED_ACTIVE_LOW}};
    end else begin
      div          <= div_nxt;
      mode_q       <= mode_level;
      cpu_clk      <= clk_nxt;
      cpu_clk_rise <= clk_nxt & ~cpu_clk;
      led_out      <= led_in ^ {LED_W{LED_ACTIVE_LOW}};
    end
endmodule

// File: tb/tb_front_panel.sv
// tb_front_panel: randomized stimulus, behavioural reference model and queue scoreboard for front_panel
module tb_front_panel;
  localparam int DB = 4;
  localparam int AD = 3;
  logic clk, rst_n, mode_raw, halt;
  logic [1:0] btn_raw, btn_level, btn_press;
  logic [5:0] led_in, led_out;
  logic mode_level, cpu_clk, cpu_clk_rise;
  typedef struct packed {
    logic [1:0] lvl;
    logic [1:0] prs;
    logic mode;
    logic clk;
    logic rise;
    logic [5:0] led;
  } exp_t;
  exp_t q[$];
  int checks = 0, errors = 0, cycle = 0;
  bit [2:0] m_s1, m_s2, m_st, m_prs;
  int m_run[3];
  bit m_mode_prev, m_clk, m_rise;
  int m_phase;
  bit [5:0] m_led;

  front_panel #(.N_BTN(2), .DB_CYCLES(DB), .AUTO_DIV(AD), .BTN_ACTIVE_LOW(1'b0),
                .LED_W(6), .LED_ACTIVE_LOW(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .mode_raw(mode_raw), .halt(halt),
    .led_in(led_in), .btn_level(btn_level), .btn_press(btn_press), .mode_level(mode_level),
    .cpu_clk(cpu_clk), .cpu_clk_rise(cpu_clk_rise), .led_out(led_out));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_step();
    bit new_clk;
    if (!rst_n) begin
      m_s1 = 0; m_s2 = 0; m_st = 0; m_prs = 0;
      m_run = '{0, 0, 0};
      m_mode_prev = 0; m_clk = 0; m_rise = 0; m_phase = 0;
      m_led = 6'h3F;
      return;
    end
    new_clk = m_clk;
    if (m_st[2] != m_mode_prev) m_phase = 0;
    else if (m_st[2]) begin
      if (m_phase == AD - 1) begin
        m_phase = 0;
        new_clk = m_clk ? 1'b0 : !halt;
      end else m_phase++;
    end else begin
      m_phase = 0;
      new_clk = m_clk ? m_st[0] : (m_st[0] && !halt);
    end
    m_rise = new_clk && !m_clk;
    m_clk = new_clk;
    m_mode_prev = m_st[2];
    // a level is accepted after DB consecutive samples that differ from it
    for (int j = 0; j < 3; j++) begin
      m_prs[j] = 0;
      if (m_s2[j] != m_st[j]) begin
        m_run[j]++;
        if (m_run[j] == DB) begin
          m_st[j] = m_s2[j];
          m_run[j] = 0;
          m_prs[j] = m_st[j];
        end
      end else m_run[j] = 0;
    end
    m_s2 = m_s1;
    m_s1 = {mode_raw, btn_raw};
    m_led = ~led_in;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    q.push_back('{m_st[1:0], m_prs[1:0], m_st[2], m_clk, m_rise, m_led});
    @(negedge clk);
    led_in = 6'($urandom);
  endtask

  task automatic chk(input string n, input logic [7:0] g, input logic [7:0] e);
    checks++;
    if (g !== e) begin
      errors++;
      $display("FAIL cycle %0d %s got %b expected %b", cycle, n, g, e);
    end
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    cycle++;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("btn_level", 8'(btn_level), 8'(e.lvl));
      chk("btn_press", 8'(btn_press), 8'(e.prs));
      chk("mode_level", 8'(mode_level), 8'(e.mode));
      chk("cpu_clk", 8'(cpu_clk), 8'(e.clk));
      chk("cpu_clk_rise", 8'(cpu_clk_rise), 8'(e.rise));
      chk("led_out", 8'(led_out), 8'(e.led));
    end
  end

  initial begin
    rst_n = 0; btn_raw = 2'b11; mode_raw = 1; halt = 1; led_in = 6'h3F;
    repeat (3) cyc();
    btn_raw = 0; mode_raw = 0; halt = 0; rst_n = 1;
    cyc();
    led_in = 6'b000101;
    repeat (8) cyc();
    for (int k = 0; k < 12; k++) begin
      btn_raw[1] = ((k / 2) % 2) == 0;
      cyc();
    end
    btn_raw[1] = 1;
    repeat (10) cyc();
    btn_raw = 0;
    repeat (8) cyc();
    mode_raw = 1;
    repeat (40) cyc();
    halt = 1;
    repeat (30) cyc();
    halt = 0;
    repeat (12) cyc();
    for (int k = 0; k < 15; k++) begin
      halt = 1'($urandom_range(0, 1));
      repeat ($urandom_range(1, 20)) cyc();
    end
    halt = 0; mode_raw = 0;
    repeat (10) cyc();
    for (int k = 0; k < 25; k++) begin
      btn_raw[0] = 1'($urandom_range(0, 1));
      halt = $urandom_range(0, 3) == 0;
      repeat ($urandom_range(1, 12)) cyc();
    end
    btn_raw = 0; halt = 1;
    repeat (8) cyc();
    btn_raw[0] = 1;
    repeat (12) cyc();
    btn_raw = 0; halt = 0;
    repeat (8) cyc();
    btn_raw[0] = 1;
    repeat (4) cyc();
    rst_n = 0;
    cyc();
    rst_n = 1;
    repeat (12) cyc();
    for (int k = 0; k < 60; k++) begin
      btn_raw = 2'($urandom);
      if ($urandom_range(0, 4) == 0) mode_raw = ~mode_raw;
      halt = $urandom_range(0, 3) == 0;
      rst_n = $urandom_range(0, 30) != 0;
      repeat ($urandom_range(1, 10)) cyc();
    end
    rst_n = 1;
    repeat (5) cyc();
    @(posedge clk);
    #2;
    chk("scoreboard_drain", 8'(q.size()), 8'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/front_panel.md
# front_panel

Parametrised board front-panel controller between the FPGA pins and the CPU core. It synchronises and debounces N push-buttons plus the clock-mode switch, and emits one-cycle press pulses. It generates the CPU clock in auto (divided) or manual (single-step) mode with halt gating, and drives a registered debug-LED bank of selectable polarity.

## Interface
Parameters:
- N_BTN, 4, number of push-button inputs; button 0 is the manual clock step button (N_BTN >= 1).
- DB_CYCLES, 270000, consecutive stable cycles required to accept a new input level (>= 1).
- AUTO_DIV, 13500000, sys-clock cycles per cpu_clk half-period in auto mode (>= 1).
- BTN_ACTIVE_LOW, 0, 1 = raw button/switch pressed when pin reads 0.
- LED_W, 6, debug LED count.
- LED_ACTIVE_LOW, 1, 1 = LED lit when pin driven 0.

Ports:
- clk  in  1  board system clock; the only clock.
- rst_n  in  1  asynchronous active-low reset.
- btn_raw  in  N_BTN  raw button pins.
- mode_raw  in  1  raw clock-mode switch (1 = auto, 0 = manual, after polarity).
- halt  in  1  halt request from control unit.
- led_in  in  LED_W  LED request bits, 1 = lit.
- btn_level  out  N_BTN  debounced button levels, 1 = pressed.
- btn_press  out  N_BTN  one-cycle pulse on each debounced press.
- mode_level  out  1  debounced mode switch.
- cpu_clk  out  1  generated CPU clock (registered).
- cpu_clk_rise  out  1  one-cycle pulse on the cycle cpu_clk becomes 1.
- led_out  out  LED_W  LED pin drive.

## Operation
- Input path (per button and the mode switch): polarity fix (XOR BTN_ACTIVE_LOW), 2-flop synchroniser, then debounce stage.
- Debounce: stable register plus counter of width clog2(DB_CYCLES)+1. If sync == stable, the counter clears. If they differ and cnt == DB_CYCLES-1, stable <= sync and cnt <= 0. Otherwise cnt increments.
- A bounce of any length restarts the count. No level is accepted until DB_CYCLES consecutive differing samples have been seen.
- btn_press[i] = stable rises 0->1, registered; high exactly one cycle. A release produces no pulse.
- Clock generator, auto mode (mode_level = 1):
  - Divider counts 0..AUTO_DIV-1.
  - At terminal count the divider returns to 0 and cpu_clk toggles.
  - A 0->1 toggle is suppressed while halt = 1: cpu_clk stays 0 and the divider still wraps.
  - A 1->0 toggle always occurs.
- Clock generator, manual mode (mode_level = 0):
  - Divider is held at 0.
  - cpu_clk <= btn_level[0] & ~(halt & ~cpu_clk). A rise is blocked by halt; a fall is never blocked.
- Mode change: divider clears on the cycle mode_level changes. cpu_clk keeps its value until the next event of the new mode.
- cpu_clk_rise: registered detection of the cpu_clk 0->1 transition, asserted in the same cycle cpu_clk first reads 1.
- LEDs: led_out <= led_in ^ {LED_W{LED_ACTIVE_LOW}}, registered.
- Reset values (rst_n = 0, asynchronous):
  - Synchronisers, stable registers, counters and divider are 0.
  - btn_level, btn_press, mode_level (manual), cpu_clk and cpu_clk_rise are 0.
  - led_out = {LED_W{LED_ACTIVE_LOW}}, i.e. all LEDs off.
- Reset asserted mid-operation returns everything to these values immediately. In-progress debounce counts are discarded, and no press pulse is generated on release of reset.

## Timing
- Debounce latency: let edge t be the first edge that samples the new raw value. The debounced level changes at edge t+DB_CYCLES+1, and btn_press rises at the same edge.
- Auto mode: cpu_clk period = 2*AUTO_DIV sys cycles, 50 % duty, when not halted.
- Manual mode: cpu_clk follows btn_level[0] with 1 cycle latency, i.e. raw-to-cpu_clk is DB_CYCLES+2 edges.
- cpu_clk_rise is coincident with the first cycle of cpu_clk = 1, so it has 0 cycles of extra latency relative to cpu_clk.
- led_in to led_out latency is 1 cycle.
- Simultaneous events:
  - halt asserting in the same cycle as a rising terminal count blocks the rise.
  - halt deasserting in the same cycle lets the rise proceed.

## Test plan
Bench parameters: DB_CYCLES=4, AUTO_DIV=3, N_BTN=2, LED_W=6, LED_ACTIVE_LOW=1.
- Reset: hold rst_n=0 with all inputs active -> all outputs 0 except led_out=6'b111111. Release reset -> no btn_press pulse.
- Bounce: btn_raw[1] toggles every 2 cycles for 12 cycles, then held 1 -> btn_level[1] rises exactly 5 edges after the first sampling edge of the final 1. btn_press[1] is one cycle wide. No earlier change occurs.
- Auto clock: mode_raw=1 debounced, halt=0 -> cpu_clk toggles every 3 cycles (period 6). cpu_clk_rise fires once per 6 cycles, coincident with the rise.
- Halt: assert halt while cpu_clk=1 -> cpu_clk falls at the next terminal count and stays 0 for 4+ periods. Deassert halt -> rises at the next terminal count.
- Manual step: mode=0, press btn 0 -> cpu_clk=1 one cycle after btn_level[0]=1. Release -> falls. Press with halt=1 -> cpu_clk stays 0 and no cpu_clk_rise.
- Reset mid-debounce and LEDs: rst_n pulses low at count 2 of a press -> counters clear and a full 4-sample window is needed afterwards. led_in=6'b000101 -> led_out=6'b111010 one cycle later.
